// File: rtl/eci_data_demux_pkg.sv
// rtl/eci_data_demux_pkg.sv - channel count and data/beat widths shared by the ECI data demux
package eci_data_demux_pkg;
  localparam int N_CHAN        = 3;
  localparam int N_CHAN_BITS   = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int ECI_DATA_BITS = 32;
  localparam int ARB_DATA_BITS = ECI_DATA_BITS;
  localparam int KEEP_BITS     = ARB_DATA_BITS / 8;
  localparam int LEN_BITS      = 5;
  localparam int BLEN_BITS     = LEN_BITS - $clog2(ARB_DATA_BITS / 8);
endpackage

// File: rtl/eci_data_demux.sv
// rtl/eci_data_demux.sv - steers the shared ECI data stream to per-channel sinks per arbiter mux entry
module eci_data_demux
  import eci_data_demux_pkg::*;
(
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              mux_valid,
  output logic                              mux_ready,
  input  logic                              mux_ctl,
  input  logic [N_CHAN_BITS-1:0]            mux_vfid,
  input  logic [BLEN_BITS-1:0]              mux_len,
  input  logic                              s_tvalid,
  output logic                              s_tready,
  input  logic [ARB_DATA_BITS-1:0]          s_tdata,
  input  logic [KEEP_BITS-1:0]              s_tkeep,
  input  logic                              s_tlast,
  output logic [N_CHAN-1:0]                 m_tvalid,
  input  logic [N_CHAN-1:0]                 m_tready,
  output logic [N_CHAN*ARB_DATA_BITS-1:0]   m_tdata,
  output logic [N_CHAN*KEEP_BITS-1:0]       m_tkeep,
  output logic [N_CHAN-1:0]                 m_tlast
);

  typedef enum logic {ST_IDLE, ST_XFER} state_t;

  state_t                 state;
  logic [N_CHAN_BITS-1:0] vfid_r;
  logic                   ctl_r;
  logic [BLEN_BITS-1:0]   cnt_r;
  logic                   drop_r;

  logic xfer;
  logic sel_ready;
  logic beat;
  logic last_beat;
  logic entry_take;
  logic unused_tlast;

  // Framing comes solely from mux_len; the source's tlast carries no meaning here.
  assign unused_tlast = s_tlast;

  assign m_tdata = {N_CHAN{s_tdata}};
  assign m_tkeep = {N_CHAN{s_tkeep}};

  always_comb begin
    xfer      = (state == ST_XFER);
    sel_ready = 1'b0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (vfid_r == N_CHAN_BITS'(i)) sel_ready = m_tready[i];
    end
    s_tready   = aresetn & xfer & (drop_r | sel_ready);
    beat       = s_tvalid & s_tready;
    last_beat  = beat & (cnt_r == '0);
    mux_ready  = aresetn & (~xfer | last_beat);
    entry_take = mux_valid & mux_ready;
    m_tvalid   = '0;
    m_tlast    = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (aresetn && xfer && !drop_r && vfid_r == N_CHAN_BITS'(i)) begin
        m_tvalid[i] = s_tvalid;
        m_tlast[i]  = (cnt_r == '0) & ctl_r;
      end
    end
  end

  // A new entry may load either from IDLE or on the final beat of the current one.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state  <= ST_IDLE;
      vfid_r <= '0;
      ctl_r  <= 1'b0;
      cnt_r  <= '0;
      drop_r <= 1'b0;
    end else if (entry_take) begin
      state  <= ST_XFER;
      vfid_r <= mux_vfid;
      ctl_r  <= mux_ctl;
      cnt_r  <= mux_len;
      drop_r <= ({1'b0, mux_vfid} >= (N_CHAN_BITS+1)'(N_CHAN));
    end else if (beat && cnt_r != '0) begin
      cnt_r <= cnt_r - BLEN_BITS'(1);
    end else if (last_beat) begin
      state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_eci_data_demux.sv
// tb/tb_eci_data_demux.sv - directed vector bench for eci_data_demux
module tb_eci_data_demux;
  import eci_data_demux_pkg::*;

  logic                            aclk = 1'b0;
  logic                            aresetn;
  logic                            mux_valid;
  logic                            mux_ready;
  logic                            mux_ctl;
  logic [N_CHAN_BITS-1:0]          mux_vfid;
  logic [BLEN_BITS-1:0]            mux_len;
  logic                            s_tvalid;
  logic                            s_tready;
  logic [ARB_DATA_BITS-1:0]        s_tdata;
  logic [KEEP_BITS-1:0]            s_tkeep;
  logic                            s_tlast;
  logic [N_CHAN-1:0]               m_tvalid;
  logic [N_CHAN-1:0]               m_tready;
  logic [N_CHAN*ARB_DATA_BITS-1:0] m_tdata;
  logic [N_CHAN*KEEP_BITS-1:0]     m_tkeep;
  logic [N_CHAN-1:0]               m_tlast;

  int total = 0;
  int bad   = 0;

  eci_data_demux dut (
    .aclk(aclk), .aresetn(aresetn),
    .mux_valid(mux_valid), .mux_ready(mux_ready), .mux_ctl(mux_ctl),
    .mux_vfid(mux_vfid), .mux_len(mux_len),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        rst_n;
    logic        mv;
    logic        ctl;
    logic [1:0]  vfid;
    logic [2:0]  len;
    logic        sv;
    logic [31:0] sd;
    logic [2:0]  mr;
    logic        er;
    logic        es;
    logic [2:0]  ev;
    logic [2:0]  el;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst_n, logic mv, logic ctl, logic [1:0] vfid,
                              logic [2:0] len, logic sv, logic [31:0] sd, logic [2:0] mr,
                              logic er, logic es, logic [2:0] ev, logic [2:0] el);
    vec_t v;
    v.rst_n = rst_n; v.mv = mv; v.ctl = ctl; v.vfid = vfid; v.len = len;
    v.sv = sv; v.sd = sd; v.mr = mr; v.er = er; v.es = es; v.ev = ev; v.el = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, compare before the next rising edge.
  task automatic apply(input string tag, input vec_t v);
    @(negedge aclk);
    aresetn   = v.rst_n;
    mux_valid = v.mv;
    mux_ctl   = v.ctl;
    mux_vfid  = v.vfid;
    mux_len   = v.len;
    s_tvalid  = v.sv;
    s_tdata   = v.sd;
    s_tkeep   = v.sd[3:0];
    s_tlast   = v.sd[0];
    m_tready  = v.mr;
    #2;
    chk({tag, ".mux_ready"}, 32'(mux_ready), 32'(v.er));
    chk({tag, ".s_tready"},  32'(s_tready),  32'(v.es));
    chk({tag, ".m_tvalid"},  32'(m_tvalid),  32'(v.ev));
    chk({tag, ".m_tlast"},   32'(m_tlast),   32'(v.el));
    for (int c = 0; c < N_CHAN; c++) begin
      chk($sformatf("%s.m_tdata%0d", tag, c), m_tdata[c*32 +: 32], v.sd);
      chk($sformatf("%s.m_tkeep%0d", tag, c), 32'(m_tkeep[c*4 +: 4]), 32'(v.sd[3:0]));
    end
  endtask

  initial begin
    //             rst mv ctl vf len sv data          mr      er es ev      el
    vecs.push_back(mk(0, 1, 1, 2, 3, 1, 32'h0000_0000, 3'b111, 0, 0, 3'b000, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0000_0000, 3'b111, 0, 0, 3'b000, 3'b000));
    // idle ignores data
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'h5555_0001, 3'b111, 1, 0, 3'b000, 3'b000));
    // single entry ctl=1 vfid=2 len=3
    vecs.push_back(mk(1, 1, 1, 2, 3, 0, 32'h0000_0000, 3'b111, 1, 0, 3'b000, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hD000_0000, 3'b111, 0, 1, 3'b100, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hD000_0011, 3'b111, 0, 1, 3'b100, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0000_0000, 3'b111, 0, 1, 3'b000, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hD000_0022, 3'b111, 0, 1, 3'b100, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hD000_0033, 3'b111, 1, 1, 3'b100, 3'b100));
    // back-to-back: (vfid0,len0,ctl0) then (vfid1,len1,ctl1)
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0000_0000, 3'b111, 1, 0, 3'b000, 3'b000));
    vecs.push_back(mk(1, 1, 1, 1, 1, 1, 32'hB000_0000, 3'b111, 1, 1, 3'b001, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hB000_0011, 3'b111, 0, 1, 3'b010, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hB000_0022, 3'b111, 1, 1, 3'b010, 3'b010));
    // backpressure on channel 1, len=2
    vecs.push_back(mk(1, 1, 1, 1, 2, 0, 32'h0000_0000, 3'b101, 1, 0, 3'b000, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hC000_0000, 3'b010, 0, 1, 3'b010, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hC000_0011, 3'b101, 0, 0, 3'b010, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hC000_0011, 3'b000, 0, 0, 3'b010, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hC000_0011, 3'b010, 0, 1, 3'b010, 3'b000));
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 32'hC000_0022, 3'b000, 0, 0, 3'b010, 3'b010));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hC000_0022, 3'b010, 1, 1, 3'b010, 3'b010));
    // out-of-range vfid=3, len=1, then a normal entry
    vecs.push_back(mk(1, 1, 1, 3, 1, 0, 32'h0000_0000, 3'b000, 1, 0, 3'b000, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hE000_0000, 3'b000, 0, 1, 3'b000, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hE000_0011, 3'b000, 1, 1, 3'b000, 3'b000));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0000_0000, 3'b001, 1, 0, 3'b000, 3'b000));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 32'hE000_0022, 3'b001, 1, 1, 3'b001, 3'b001));

    foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i]);

    // Maximum length: 2^BLEN_BITS beats, tlast and completion only on the final one
    apply("max.entry", mk(1, 1, 1, 0, 3'd7, 0, 32'h0, 3'b001, 1, 0, 3'b000, 3'b000));
    for (int b = 0; b < 8; b++)
      apply($sformatf("max.beat%0d", b),
            mk(1, 0, 0, 0, 0, 1, 32'hA000_0000 + 32'(b), 3'b001,
               (b == 7), 1, 3'b001, (b == 7) ? 3'b001 : 3'b000));
    apply("max.idle", mk(1, 0, 0, 0, 0, 1, 32'h0, 3'b001, 1, 0, 3'b000, 3'b000));

    // Reset after one of four beats abandons the rest
    apply("rst.entry", mk(1, 1, 1, 2, 3, 0, 32'h0, 3'b111, 1, 0, 3'b000, 3'b000));
    apply("rst.beat0", mk(1, 0, 0, 0, 0, 1, 32'hF000_0000, 3'b111, 0, 1, 3'b100, 3'b000));
    apply("rst.hold",  mk(0, 1, 1, 2, 0, 1, 32'hF000_0011, 3'b111, 0, 0, 3'b000, 3'b000));
    apply("rst.idle",  mk(1, 0, 0, 0, 0, 1, 32'hF000_0022, 3'b111, 1, 0, 3'b000, 3'b000));
    apply("rst.new",   mk(1, 1, 1, 1, 1, 0, 32'h0, 3'b111, 1, 0, 3'b000, 3'b000));
    apply("rst.b0",    mk(1, 0, 0, 0, 0, 1, 32'h9000_0000, 3'b111, 0, 1, 3'b010, 3'b000));
    apply("rst.b1",    mk(1, 0, 0, 0, 0, 1, 32'h9000_0011, 3'b111, 1, 1, 3'b010, 3'b010));
    apply("rst.end",   mk(1, 0, 0, 0, 0, 0, 32'h0, 3'b111, 1, 0, 3'b000, 3'b000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eci_data_demux.md
# eci_data_demux

Data-path companion to the ECI request arbiter. It consumes the multiplexing sequence (ctl, vfid, beat count) that the arbiter emits per granted request and steers the single shared ECI data stream to the matching per-channel sink. The data path is zero-latency and bubble-free across request boundaries. It sits between the ECI data source and the N_CHAN user data ports.

## Interface
- N_CHAN, from package: number of user channels.
- N_CHAN_BITS, from package: vfid width, clog2(N_CHAN), minimum 1.
- ARB_DATA_BITS, ECI_DATA_BITS: data beat width.
- BLEN_BITS, LEN_BITS - clog2(ARB_DATA_BITS/8): beat-count width.
---
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- mux_valid  in  1  sequence entry valid
- mux_ready  out  1  sequence entry accepted
- mux_ctl  in  1  entry is final chunk of a transfer
- mux_vfid  in  N_CHAN_BITS  target channel
- mux_len  in  BLEN_BITS  beats minus one
- s_tvalid / s_tready  in / out  1  shared data stream handshake
- s_tdata  in  ARB_DATA_BITS  data
- s_tkeep  in  ARB_DATA_BITS/8  byte enables
- s_tlast  in  1  ignored; framing comes from mux_len
- m_tvalid[N_CHAN] / m_tready[N_CHAN]  out / in  1 each  per-channel handshake
- m_tdata[N_CHAN], m_tkeep[N_CHAN]  out  as above  per-channel data, keep
- m_tlast[N_CHAN]  out  1 each  last beat of a ctl chunk

## Operation
- FSM with two states: IDLE and XFER. Registers: vfid_r, ctl_r, cnt_r (BLEN_BITS), drop_r.
- IDLE: mux_ready=1. On mux_valid&mux_ready: vfid_r<=mux_vfid, ctl_r<=mux_ctl, cnt_r<=mux_len, drop_r<=(mux_vfid>=N_CHAN), go XFER. In IDLE, s_tready=0 and all m_tvalid=0.
- XFER, normal: m_tvalid[vfid_r]=s_tvalid, s_tready=m_tready[vfid_r]. m_tdata and m_tkeep of every channel equal s_tdata and s_tkeep; only m_tvalid is steered. m_tlast[vfid_r]=(cnt_r==0)&ctl_r. All other channels: m_tvalid=0, m_tlast=0.
- XFER, drop (vfid out of range): s_tready=1. No m_tvalid asserts. Beats are counted and discarded.
- Beat handshake (s_tvalid&s_tready): if cnt_r!=0, cnt_r<=cnt_r-1. If cnt_r==0, the request is complete.
- Completion: mux_ready=1 in the same cycle as the last-beat handshake.
  - If mux_valid is also high, load the new entry and stay in XFER (back-to-back, no bubble).
  - Otherwise go to IDLE.
  - mux_ready is 0 during XFER in any other cycle.
- mux_len arithmetic is unsigned. mux_len=0 means 1 beat. The maximum value 2^BLEN_BITS-1 must not wrap; cnt_r only decrements when nonzero.
- No assumption on the relation between s_tlast and mux_len. The source provides exactly mux_len+1 beats per entry.

## Timing
- Reset (aresetn=0 at a clock edge): state IDLE, cnt_r=0, vfid_r=0, ctl_r=0, drop_r=0. While aresetn=0, mux_ready, s_tready, all m_tvalid and all m_tlast are forced to 0.
- Reset mid-transfer abandons the remaining beats. No partial state survives.
- Data latency: 0 cycles, combinational s->m. Handshake signals follow AXI-Stream rules:
  - valid is never conditioned on ready from the same side.
  - s_tready depends only on registered state and m_tready[vfid_r].
- First beat of an entry is accepted no earlier than the cycle after the entry handshake from IDLE. Back-to-back entries give 100% beat throughput.
- mux_ready depends combinationally on s_tvalid and m_tready only in XFER at cnt_r==0. There is no path from mux_valid to mux_ready.

## Structure
- BLEN_BITS derivation and N_CHAN/N_CHAN_BITS/ECI_DATA_BITS live in lynxTypes. No new typedefs beyond an enum for the FSM states (local to the module).
- Single flat module. No sub-module is required. Insertion of an optional output register slice is left to the integrating top level.

## Test plan
- Single entry (ctl=1, vfid=2, len=3), 4 beats D0..D3 with m_tready all 1 -> channel 2 receives D0..D3 in order, m_tlast only on D3, other channels never valid.
- Back-to-back entries (vfid=0, len=0, ctl=0) then (vfid=1, len=1, ctl=1) with the second entry already valid -> 3 consecutive beat handshakes without a bubble. Channel 0 gets 1 beat with tlast=0; channel 1 gets 2 beats with tlast on the second.
- Backpressure: m_tready[1] toggled 1,0,0,1 during len=2 -> s_tready mirrors it, no beat lost or duplicated, cnt_r holds while stalled.
- Out-of-range vfid (N_CHAN=3, vfid=3, len=1) -> 2 beats consumed with s_tready=1, no m_tvalid. Next entry routed normally.
- Max length (len=2^BLEN_BITS-1) -> exactly 2^BLEN_BITS beats forwarded, no counter wrap.
- aresetn=0 after 1 of 4 beats -> all outputs 0 while in reset. After release, mux_ready=1 and a new entry works from beat 0.
